if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port stall  input  1  ID stage cannot accept a new IF/ID entry.
REQ-005 SHALL have port flush  input  1  redirect from EX; kill fetched/in-flight instructions.
REQ-006 SHALL have port redirect_pc  input  32  new fetch address when flush=1.
REQ-007 SHALL have port imem_req  output  1  fetch request valid (registered).
REQ-008 SHALL have port imem_addr  output  32  fetch address (registered), word-aligned.
REQ-009 SHALL have port imem_valid  input  1  response valid; accepted only while imem_req=1.
REQ-010 SHALL have port imem_rdata  input  32  instruction word, valid when imem_valid=1.
REQ-011 SHALL have port ifid_valid  output  1  IF/ID entry holds a live instruction.
REQ-012 SHALL have port ifid_instr  output  32  IF/ID instruction, feeds decode/immediate generation.
REQ-013 SHALL have port ifid_pc  output  32  address of ifid_instr.
REQ-014 SHALL have port ifid_pred_taken  output  1  fetch predicted this branch taken.

Function
REQ-015 SHALL keep at most one imem request outstanding; imem_req and imem_addr SHALL stay stable until imem_valid=1 is sampled.
REQ-016 SHALL use FSM states FETCH (request outstanding), HOLD (response parked, ID stalled), DROP (in-flight request killed by flush).
REQ-017 FETCH, imem_valid=1, and (stall=0 or ifid_valid=0): SHALL load IF/ID with rdata/addr, set ifid_valid=1, issue next request next cycle (back-to-back, no idle cycle).
REQ-018 FETCH, imem_valid=1, stall=1, ifid_valid=1: SHALL park rdata/addr in a hold register, drop imem_req, go to HOLD; IF/ID unchanged.
REQ-019 HOLD, stall=0: SHALL move hold register into IF/ID, reassert imem_req with next address, return to FETCH.
REQ-020 FETCH, imem_valid=0, stall=0: SHALL clear ifid_valid (bubble); with stall=1 SHALL keep IF/ID unchanged.
REQ-021 Next address SHALL be imem_addr+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-022 flush=1 SHALL take priority over stall and responses: clear ifid_valid, discard hold register, set fetch pc to {redirect_pc[31:2],2'b00}.
REQ-023 flush with request outstanding and imem_valid=0: SHALL enter DROP, keep imem_req=1 at old addr, discard the arriving response, then request redirect pc next cycle.
REQ-024 flush in the same cycle as imem_valid=1, or in HOLD: SHALL discard the response and request the redirect pc next cycle.
REQ-025 flush during DROP SHALL update the pending redirect pc (last flush wins).
REQ-026 ifid_instr SHALL read 32'h0000_0013 (NOP) whenever ifid_valid is cleared by flush.

Reset
REQ-027 rst_n=0 SHALL immediately force imem_req=0, imem_addr=RESET_PC, ifid_valid=0, ifid_instr=32'h0000_0013, ifid_pc=0, ifid_pred_taken=0, state FETCH, hold empty.
REQ-028 First rising edge with rst_n=1 SHALL assert imem_req with imem_addr=RESET_PC.
REQ-029 Reset mid-request SHALL abandon the request; a response arriving while imem_req=0 SHALL be ignored.

Configuration
REQ-030 Macro IF_STATIC_PREDICT_EN defined: on accepting a response with opcode 7'b1100011 and instr[31]=1, next address SHALL be addr + sign-extended B-immediate {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}, and that entry's ifid_pred_taken=1.
REQ-031 Macro undefined: next address always addr+4; ifid_pred_taken tied 0.

Verification
REQ-032 Reset release, imem_valid=1 every cycle, stall=0 -> addresses 0,4,8,... one per cycle; ifid_pc trails imem_addr by one cycle.
REQ-033 stall=1 for 3 cycles while response at addr 8 arrives -> imem_req drops, IF/ID holds addr 4; stall=0 -> IF/ID=8 next edge, request 12 follows.
REQ-034 flush with redirect_pc=32'h0000_0102 while addr 16 outstanding -> response for 16 dropped, next request 32'h0000_0100, no live IF/ID entry for 16.
REQ-035 flush and stall and imem_valid same cycle -> ifid_valid=0, ifid_instr=32'h0000_0013, next request redirect pc.
REQ-036 IF_STATIC_PREDICT_EN: instr 32'hFE00_0EE3 (beq x0,x0,-4) at addr 32'h40 -> next request 32'h3C, ifid_pred_taken=1; undefined -> 32'h44, ifid_pred_taken=0.
REQ-037 imem_addr=32'hFFFF_FFFC response -> next request 32'h0000_0000.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between if_stage (master) and the instruction memory (slave).
// One request outstanding at a time; req/addr stay stable until valid is sampled.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Fetch stage: single outstanding imem request, IF/ID register, one-entry park buffer, flush handling.
// Define IF_STATIC_PREDICT_EN for static backward-branch-taken prediction.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    if_stage_if.master  imem,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_pred_taken
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t      state;
    logic        req_q;
    logic [31:0] addr_q;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic [31:0] pend_pc;
    logic [31:0] flush_pc;
    logic [31:0] src_instr;
    logic [31:0] src_pc;
    logic [31:0] src_next;
    logic        src_taken;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign flush_pc       = redirect_pc & 32'hFFFF_FFFC;

    // The instruction entering IF/ID comes from the park buffer in HOLD, else straight from imem.
    assign src_instr = (state == HOLD) ? hold_instr : imem.imem_rdata;
    assign src_pc    = (state == HOLD) ? hold_pc    : addr_q;

`ifdef IF_STATIC_PREDICT_EN
    logic [31:0] bimm;
    assign bimm      = {{20{src_instr[31]}}, src_instr[7], src_instr[30:25], src_instr[11:8], 1'b0};
    assign src_taken = (src_instr[6:0] == 7'b1100011) && src_instr[31];
    assign src_next  = src_taken ? (src_pc + bimm) : (src_pc + 32'd4);
`else
    assign src_taken = 1'b0;
    assign src_next  = src_pc + 32'd4;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= FETCH;
            req_q           <= 1'b0;
            addr_q          <= RESET_PC;
            hold_instr      <= NOP;
            hold_pc         <= '0;
            pend_pc         <= '0;
            ifid_valid      <= 1'b0;
            ifid_instr      <= NOP;
            ifid_pc         <= '0;
            ifid_pred_taken <= 1'b0;
        end else begin
            if (flush) begin
                ifid_valid      <= 1'b0;
                ifid_instr      <= NOP;
                ifid_pred_taken <= 1'b0;
            end
            unique case (state)
                FETCH: begin
                    if (flush) begin
                        // An unanswered request must still complete; its response is dropped later.
                        if (req_q && !imem.imem_valid) begin
                            state   <= DROP;
                            pend_pc <= flush_pc;
                        end else begin
                            req_q  <= 1'b1;
                            addr_q <= flush_pc;
                        end
                    end else if (!req_q) begin
                        req_q <= 1'b1;
                        if (!stall) ifid_valid <= 1'b0;
                    end else if (imem.imem_valid) begin
                        if (!stall || !ifid_valid) begin
                            ifid_valid      <= 1'b1;
                            ifid_instr      <= src_instr;
                            ifid_pc         <= src_pc;
                            ifid_pred_taken <= src_taken;
                            addr_q          <= src_next;
                        end else begin
                            hold_instr <= imem.imem_rdata;
                            hold_pc    <= addr_q;
                            req_q      <= 1'b0;
                            state      <= HOLD;
                        end
                    end else if (!stall) begin
                        ifid_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        req_q  <= 1'b1;
                        addr_q <= flush_pc;
                        state  <= FETCH;
                    end else if (!stall) begin
                        ifid_valid      <= 1'b1;
                        ifid_instr      <= src_instr;
                        ifid_pc         <= src_pc;
                        ifid_pred_taken <= src_taken;
                        addr_q          <= src_next;
                        req_q           <= 1'b1;
                        state           <= FETCH;
                    end
                end
                DROP: begin
                    if (flush) pend_pc <= flush_pc;
                    if (imem.imem_valid) begin
                        addr_q <= flush ? flush_pc : pend_pc;
                        state  <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand sequences and a random
// stream checked against an instruction-stream reference model.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam bit L = 1'b0;
    localparam bit H = 1'b1;
`ifdef IF_STATIC_PREDICT_EN
    localparam logic [31:0] BR_NEXT = 32'h0000_003C;
    localparam bit          BR_PRED = 1'b1;
`else
    localparam logic [31:0] BR_NEXT = 32'h0000_0044;
    localparam bit          BR_PRED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_pred_taken;

    int checks = 0;
    int errors = 0;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .imem            (bus),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pred_taken (ifid_pred_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        fl;
        logic        v;
        logic [31:0] rdata;
        logic [31:0] redir;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [1:0]  cm;      // 0: no entry check, 1: instr only, 2: pc, instr and pred
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vt[$];

    // Memory image: every word is a non-branch ALU op derived from its address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[24:0], 7'h13};
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic fl, input logic v, input logic [31:0] rdata,
                       input logic [31:0] redir, input logic e_req, input logic [31:0] e_addr,
                       input logic e_iv, input logic [1:0] cm, input logic [31:0] e_pc,
                       input logic [31:0] e_instr);
        vec_t r;
        r.st = st; r.fl = fl; r.v = v; r.rdata = rdata; r.redir = redir;
        r.e_req = e_req; r.e_addr = e_addr; r.e_iv = e_iv; r.cm = cm;
        r.e_pc = e_pc; r.e_instr = e_instr;
        vt.push_back(r);
    endtask

    initial begin
        logic        p_req, p_v, drv_v;
        logic [31:0] p_addr, p_pc, p_in, exp_pc;
        int          delivered;

        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk1 ("rst_req",   bus.imem_req, 1'b0);
        chk32("rst_addr",  bus.imem_addr, 32'h0);
        chk1 ("rst_valid", ifid_valid, 1'b0);
        chk32("rst_instr", ifid_instr, NOP);
        chk32("rst_pc",    ifid_pc, 32'h0);
        chk1 ("rst_pred",  ifid_pred_taken, 1'b0);
        step();
        rst_n = 1'b1;

        // st fl v rdata redir | req addr iv cm pc instr
        add(L, L, L, 32'h0,       32'h0,   H, 32'h0,   L, 2'd2, 32'h0,   NOP);
        add(L, L, H, 32'h13,      32'h0,   H, 32'h4,   H, 2'd2, 32'h0,   32'h13);
        add(L, L, H, 32'h213,     32'h0,   H, 32'h8,   H, 2'd2, 32'h4,   32'h213);
        add(H, L, H, 32'h413,     32'h0,   L, 32'h8,   H, 2'd2, 32'h4,   32'h213);
        add(H, L, L, 32'h0,       32'h0,   L, 32'h8,   H, 2'd2, 32'h4,   32'h213);
        add(H, L, L, 32'h0,       32'h0,   L, 32'h8,   H, 2'd2, 32'h4,   32'h213);
        add(L, L, L, 32'h0,       32'h0,   H, 32'hC,   H, 2'd2, 32'h8,   32'h413);
        add(L, L, H, 32'h613,     32'h0,   H, 32'h10,  H, 2'd2, 32'hC,   32'h613);
        add(L, L, L, 32'h0,       32'h0,   H, 32'h10,  L, 2'd0, 32'h0,   32'h0);
        add(L, H, L, 32'h0,       32'h102, H, 32'h10,  L, 2'd1, 32'h0,   NOP);
        add(L, L, H, 32'h813,     32'h0,   H, 32'h100, L, 2'd0, 32'h0,   32'h0);
        add(L, L, H, 32'h8013,    32'h0,   H, 32'h104, H, 2'd2, 32'h100, 32'h8013);
        add(H, H, H, 32'h8213,    32'h200, H, 32'h200, L, 2'd1, 32'h0,   NOP);
        add(H, L, H, 32'h10013,   32'h0,   H, 32'h204, H, 2'd2, 32'h200, 32'h10013);
        add(H, L, H, 32'h10213,   32'h0,   L, 32'h204, H, 2'd2, 32'h200, 32'h10013);
        add(H, H, L, 32'h0,       32'h33,  H, 32'h30,  L, 2'd1, 32'h0,   NOP);
        add(L, H, L, 32'h0,       32'h50,  H, 32'h30,  L, 2'd1, 32'h0,   NOP);
        add(L, H, L, 32'h0,       32'h64,  H, 32'h30,  L, 2'd1, 32'h0,   NOP);
        add(L, L, H, 32'h1813,    32'h0,   H, 32'h64,  L, 2'd0, 32'h0,   32'h0);
        add(L, L, H, 32'h3213,    32'h0,   H, 32'h68,  H, 2'd2, 32'h64,  32'h3213);

        foreach (vt[i]) begin
            stall = vt[i].st; flush = vt[i].fl; redirect_pc = vt[i].redir;
            bus.imem_valid = vt[i].v; bus.imem_rdata = vt[i].rdata;
            step();
            chk1 ($sformatf("v%0d_req", i),   bus.imem_req, vt[i].e_req);
            chk32($sformatf("v%0d_addr", i),  bus.imem_addr, vt[i].e_addr);
            chk1 ($sformatf("v%0d_valid", i), ifid_valid, vt[i].e_iv);
            if (vt[i].cm != 2'd0) chk32($sformatf("v%0d_instr", i), ifid_instr, vt[i].e_instr);
            if (vt[i].cm == 2'd2) begin
                chk32($sformatf("v%0d_pc", i), ifid_pc, vt[i].e_pc);
                chk1 ($sformatf("v%0d_pred", i), ifid_pred_taken, 1'b0);
            end
        end
        stall = 1'b0; flush = 1'b0;

        // Backward branch at 0x40
        flush = 1'b1; redirect_pc = 32'h40; bus.imem_valid = 1'b0;
        step();
        flush = 1'b0; bus.imem_valid = 1'b1; bus.imem_rdata = 32'h0000_1813;
        step();
        chk32("br_req_addr", bus.imem_addr, 32'h40);
        bus.imem_rdata = 32'hFE00_0EE3;
        step();
        chk32("br_pc",   ifid_pc, 32'h40);
        chk32("br_inst", ifid_instr, 32'hFE00_0EE3);
        chk1 ("br_pred", ifid_pred_taken, BR_PRED);
        chk32("br_next", bus.imem_addr, BR_NEXT);

        // Address wrap
        flush = 1'b1; redirect_pc = 32'hFFFF_FFFE; bus.imem_rdata = mem(BR_NEXT);
        step();
        chk32("wrap_redir", bus.imem_addr, 32'hFFFF_FFFC);
        chk1 ("wrap_flush_v", ifid_valid, 1'b0);
        flush = 1'b0; bus.imem_rdata = mem(32'hFFFF_FFFC);
        step();
        chk32("wrap_pc",   ifid_pc, 32'hFFFF_FFFC);
        chk32("wrap_next", bus.imem_addr, 32'h0);
        bus.imem_rdata = mem(32'h0);
        step();
        chk32("wrap_pc0",  ifid_pc, 32'h0);
        chk32("wrap_next4", bus.imem_addr, 32'h4);

        // Reset while a request is outstanding; response during reset is ignored
        bus.imem_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk1 ("mrst_req",   bus.imem_req, 1'b0);
        chk32("mrst_addr",  bus.imem_addr, 32'h0);
        chk1 ("mrst_valid", ifid_valid, 1'b0);
        chk32("mrst_instr", ifid_instr, NOP);
        bus.imem_valid = 1'b1; bus.imem_rdata = 32'h1234_5613;
        step();
        chk1("mrst_hold_req", bus.imem_req, 1'b0);
        rst_n = 1'b1; bus.imem_valid = 1'b0;
        step();
        chk1 ("mrst_rel_req",  bus.imem_req, 1'b1);
        chk32("mrst_rel_addr", bus.imem_addr, 32'h0);
        chk1 ("mrst_rel_v",    ifid_valid, 1'b0);

        // Random stream: delivered entries must follow the program order, restarting at each redirect
        exp_pc = 32'h0;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            p_req = bus.imem_req; p_addr = bus.imem_addr;
            p_v = ifid_valid; p_pc = ifid_pc; p_in = ifid_instr;
            stall = ($urandom_range(0, 99) < 30);
            flush = ($urandom_range(0, 99) < 4);
            redirect_pc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                                      : 32'($urandom_range(0, 32'h3FFF));
            if (p_req) begin
                drv_v = ($urandom_range(0, 99) < 60);
                bus.imem_rdata = mem(p_addr);
            end else begin
                drv_v = ($urandom_range(0, 99) < 20);
                bus.imem_rdata = 32'hDEAD_BEEF;
            end
            bus.imem_valid = drv_v;
            step();
            if (p_req && !drv_v) begin
                chk1 ("rnd_req_stable",  bus.imem_req, 1'b1);
                chk32("rnd_addr_stable", bus.imem_addr, p_addr);
            end
            if (flush) begin
                chk1 ("rnd_flush_v",     ifid_valid, 1'b0);
                chk32("rnd_flush_instr", ifid_instr, NOP);
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (p_v && stall) begin
                chk1 ("rnd_stall_v",     ifid_valid, 1'b1);
                chk32("rnd_stall_pc",    ifid_pc, p_pc);
                chk32("rnd_stall_instr", ifid_instr, p_in);
            end else if (ifid_valid) begin
                chk32("rnd_pc",    ifid_pc, exp_pc);
                chk32("rnd_instr", ifid_instr, mem(exp_pc));
                chk1 ("rnd_pred",  ifid_pred_taken, 1'b0);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
        end
        chk1("rnd_progress", delivered > 200, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
